// File: rtl/mux_channel_scanner_pkg.sv
// Shared types and constants for the mux channel scanner: channel count, select width,
// FSM encoding and default divider settings.
package mux_scan_pkg;

  localparam int NUM_CH        = 4;
  localparam int SEL_W         = 2;
  localparam int DEF_DIV_MAX   = 49_999_999;
  localparam int DEF_DIV_WIDTH = 26;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] frame_t;

  function automatic sel_t sel_next(input sel_t s);
    return s + sel_t'(1);
  endfunction

endpackage

// File: rtl/mux_channel_scanner_if.sv
// Control and result bundle between the scanner and its driver.
// The slave modport is the scanner side; master is the driver side.
interface mux_channel_scanner_if;
  import mux_scan_pkg::*;

  logic   enable;
  logic   manual;
  logic   step;
  logic   mux_in;
  sel_t   sel;
  frame_t frame;
  logic   frame_valid;
  logic   busy;

  modport master (
    output enable, manual, step, mux_in,
    input  sel, frame, frame_valid, busy
  );

  modport slave (
    input  enable, manual, step, mux_in,
    output sel, frame, frame_valid, busy
  );

endinterface

// File: rtl/mux_channel_scanner_rate_divider.sv
// Dwell timer: down-counter that pulses tick for one cycle every DIV_MAX+1 cycles while run is high.
// Tick is combinational on the count reaching zero; no backpressure, the counter reloads whenever run is low.
module rate_divider
  import mux_scan_pkg::*;
#(
  parameter int DIV_MAX   = DEF_DIV_MAX,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (!resetn || !run || count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - DIV_WIDTH'(1);
    end
  end

  assign tick = run && (count == '0);

endmodule

// File: rtl/mux_channel_scanner.sv
// Scans mux channels 0..3 (divider tick or step edge) and publishes a 4-bit frame with a one-cycle valid pulse.
// Sample lands one clock after the tick (+2 with MUX_SCAN_SYNC_EN); no backpressure, frames are overwritten.
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int DIV_MAX   = DEF_DIV_MAX,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  mux_channel_scanner_if.slave  bus
);

  state_t state_q, state_d;
  sel_t   sel_q, sel_d;
  frame_t shadow_q, shadow_d;
  frame_t frame_q, frame_d;
  logic   fv_q, fv_d;

  logic step_use;
  logic mux_use;
  logic step_q;
  logic step_edge;
  logic div_run;
  logic div_tick;
  logic tick;

  logic samp_vld;
  sel_t samp_sel;
  logic samp_dat;

`ifdef MUX_SCAN_SYNC_EN
  logic [1:0] step_sync;
  logic [1:0] mux_sync;
  logic [1:0] pend_vld;
  sel_t       pend_sel0, pend_sel1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      step_sync <= '0;
      mux_sync  <= '0;
    end else begin
      step_sync <= {step_sync[0], bus.step};
      mux_sync  <= {mux_sync[0], bus.mux_in};
    end
  end

  assign step_use = step_sync[1];
  assign mux_use  = mux_sync[1];

  // Delay each sample command to line up with mux_in emerging from the synchroniser.
  always_ff @(posedge clock) begin
    if (!resetn || state_q != ST_SCAN || !bus.enable) begin
      pend_vld  <= '0;
      pend_sel0 <= '0;
      pend_sel1 <= '0;
    end else begin
      pend_vld  <= {pend_vld[0], tick};
      pend_sel0 <= sel_q;
      pend_sel1 <= pend_sel0;
    end
  end

  assign samp_vld = pend_vld[1];
  assign samp_sel = pend_sel1;
  assign samp_dat = mux_use;
`else
  assign step_use = bus.step;
  assign mux_use  = bus.mux_in;
  assign samp_vld = tick;
  assign samp_sel = sel_q;
  assign samp_dat = mux_use;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_use;
    end
  end

  assign step_edge = step_use & ~step_q;

  // Holding the divider in reload while manual keeps a mode switch from producing a stray tick.
  assign div_run = (state_q == ST_SCAN) && !bus.manual;

  rate_divider #(
    .DIV_MAX   (DIV_MAX),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_divider (
    .clock  (clock),
    .resetn (resetn),
    .run    (div_run),
    .tick   (div_tick)
  );

  assign tick = (state_q == ST_SCAN) && (bus.manual ? step_edge : div_tick);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Dropping enable outranks any tick in the same cycle and discards the partial frame.
        if (!bus.enable) begin
          state_d  = ST_IDLE;
          shadow_d = '0;
        end else begin
          if (tick) sel_d = sel_next(sel_q);
          if (samp_vld) begin
            shadow_d[samp_sel] = samp_dat;
            if (samp_sel == sel_t'(NUM_CH-1)) begin
              frame_d = {samp_dat, shadow_q[NUM_CH-2:0]};
              fv_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner with DIV_MAX = 3; the mux is modelled as pat[sel].
module tb_mux_channel_scanner;
  import mux_scan_pkg::*;

`ifdef MUX_SCAN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] pat;
  int         n_tests = 0;
  int         n_fail  = 0;

  mux_channel_scanner_if bus ();

  assign bus.mux_in = pat[bus.sel];

  mux_channel_scanner #(
    .DIV_MAX   (3),
    .DIV_WIDTH (4)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One button press: high 10 cycles, low 5; counts frame_valid pulses seen meanwhile.
  task automatic press(input logic [1:0] exp_sel, input int exp_fv);
    int fv;
    fv = 0;
    bus.step = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (bus.frame_valid) fv++;
    end
    bus.step = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (bus.frame_valid) fv++;
    end
    check("press_sel", 32'(bus.sel), 32'(exp_sel));
    check("press_fv_count", 32'(fv), 32'(exp_fv));
  endtask

  initial begin
    resetn     = 1'b0;
    bus.enable = 1'b1;
    bus.manual = 1'b0;
    bus.step   = 1'b0;
    pat        = 4'b1010;
    cyc(3);
    check("rst_sel",   32'(bus.sel),         32'd0);
    check("rst_frame", 32'(bus.frame),       32'd0);
    check("rst_fv",    32'(bus.frame_valid), 32'd0);
    check("rst_busy",  32'(bus.busy),        32'd0);

    resetn = 1'b1;
    cyc(1);
    check("busy_after_release", 32'(bus.busy), 32'd1);

    // Auto scan: sel dwells 4 cycles per channel, frame_valid once per 16 cycles.
    for (int k = 1; k <= 36; k++) begin
      if (k > 1) cyc(1);
      if ((k - 1) % 4 == 0) check("auto_sel", 32'(bus.sel), 32'(((k - 1) / 4) % 4));
      check("auto_fv", 32'(bus.frame_valid), 32'(k == 17 + LAT || k == 33 + LAT));
    end
    check("auto_frame", 32'(bus.frame), 32'h0000000a);

    // Enable drops on the cycle of a tick: no sample, sel stays.
    bus.enable = 1'b0;
    cyc(1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_sel",  32'(bus.sel),  32'd0);
    check("idle_fv",   32'(bus.frame_valid), 32'd0);

    // Manual scan, pattern 0110.
    bus.manual = 1'b1;
    bus.enable = 1'b1;
    pat        = 4'b0110;
    cyc(1);
    press(2'd1, 0);
    press(2'd2, 0);
    press(2'd3, 0);
    check("man_frame_hold", 32'(bus.frame), 32'h0000000a);
    press(2'd0, 1);
    check("man_frame", 32'(bus.frame), 32'h00000006);

    // Abort at sel = 2: shadow for channels 0,1 must be discarded.
    pat = 4'b1111;
    press(2'd1, 0);
    press(2'd2, 0);
    bus.enable = 1'b0;
    cyc(1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sel",  32'(bus.sel),  32'd2);
    cyc(3);
    check("abort_frame", 32'(bus.frame), 32'h00000006);
    check("abort_fv",    32'(bus.frame_valid), 32'd0);
    bus.enable = 1'b1;
    cyc(1);
    press(2'd3, 0);
    press(2'd0, 1);
    check("abort_next_frame", 32'(bus.frame), 32'h0000000c);

    // Reset on the sel = 3 tick cycle.
    press(2'd1, 0);
    press(2'd2, 0);
    press(2'd3, 0);
    bus.step = 1'b1;
    resetn   = 1'b0;
    cyc(1);
    check("midrst_sel",   32'(bus.sel),         32'd0);
    check("midrst_frame", 32'(bus.frame),       32'd0);
    check("midrst_fv",    32'(bus.frame_valid), 32'd0);
    check("midrst_busy",  32'(bus.busy),        32'd0);
    cyc(3);
    check("midrst_fv_hold", 32'(bus.frame_valid), 32'd0);
    bus.step = 1'b0;
    resetn   = 1'b1;
    cyc(2);
    check("post_rst_busy", 32'(bus.busy), 32'd1);
    check("post_rst_sel",  32'(bus.sel),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
